// File: rtl/instr_pipe_buffer.sv
// Instruction buffer between fetch (IF) and decode (ID): a circular queue of
// {instr, pc, pc_plus4} entries with flush, stall and a saturating drop counter.
module instr_pipe_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              STALL,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] Instr1_IF,
    input  logic [31:0]       Instr_PC_IF,
    input  logic [31:0]       Instr_PC_Plus4_IF,
    output logic              IN_READY,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] Instr1_OUT,
    output logic [31:0]       Instr_PC_OUT,
    output logic [31:0]       Instr_PC_Plus4,
    output logic [CW-1:0]     COUNT,
    output logic [15:0]       FLUSH_DROPS
);

    localparam int              PW      = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_C  = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem_instr_q [DEPTH];
    logic [31:0]       mem_pc_q    [DEPTH];
    logic [31:0]       mem_pc4_q   [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   flush_drops_q, flush_drops_d;
    logic          push_s, pop_s;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_C) ? '0 : ptr + PW'(1);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [CW-1:0] add);
        logic [16:0] sum;
        sum = {1'b0, acc} + 17'(add);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign push_s = IN_VALID && (count_q < DEPTH_C) && !FLUSH;
    assign pop_s  = (count_q != '0) && !STALL && !FLUSH;

    // Next-state for occupancy, pointers and the drop counter.
    always_comb begin
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        flush_drops_d = flush_drops_q;
        if (FLUSH) begin
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            flush_drops_d = sat_add(flush_drops_q, count_q);
        end else begin
            if (push_s) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; RESET overrides FLUSH so no drops are counted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            flush_drops_q <= 16'h0000;
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            flush_drops_q <= flush_drops_d;
        end
    end

    // Entry storage; unoccupied slots are never shown, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push_s && !RESET) begin
            mem_instr_q[wr_ptr_q] <= Instr1_IF;
            mem_pc_q[wr_ptr_q]    <= Instr_PC_IF;
            mem_pc4_q[wr_ptr_q]   <= Instr_PC_Plus4_IF;
        end
    end

    // Head view: a zero bubble whenever the queue is empty.
    always_comb begin
        Instr1_OUT     = '0;
        Instr_PC_OUT   = 32'h0000_0000;
        Instr_PC_Plus4 = 32'h0000_0000;
        if (count_q != '0) begin
            Instr1_OUT     = mem_instr_q[rd_ptr_q];
            Instr_PC_OUT   = mem_pc_q[rd_ptr_q];
            Instr_PC_Plus4 = mem_pc4_q[rd_ptr_q];
        end else begin
            Instr1_OUT     = '0;
            Instr_PC_OUT   = 32'h0000_0000;
            Instr_PC_Plus4 = 32'h0000_0000;
        end
    end

    assign IN_READY    = (count_q < DEPTH_C);
    assign OUT_VALID   = (count_q != '0);
    assign COUNT       = count_q;
    assign FLUSH_DROPS = flush_drops_q;

endmodule

// File: tb/tb_instr_pipe_buffer.sv
// Randomized bench for instr_pipe_buffer against a queue-based reference model.
module tb_instr_pipe_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              FLUSH = 1'b0;
    logic              STALL = 1'b0;
    logic              IN_VALID = 1'b0;
    logic [DATA_W-1:0] Instr1_IF = '0;
    logic [31:0]       Instr_PC_IF = 32'h0;
    logic [31:0]       Instr_PC_Plus4_IF = 32'h0;
    logic              IN_READY, OUT_VALID;
    logic [DATA_W-1:0] Instr1_OUT;
    logic [31:0]       Instr_PC_OUT, Instr_PC_Plus4;
    logic [CW-1:0]     COUNT;
    logic [15:0]       FLUSH_DROPS;

    int     err_cnt = 0;
    int     chk_cnt = 0;
    entry_t mq[$];
    int     m_drops = 0;

    instr_pipe_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL), .IN_VALID(IN_VALID),
        .Instr1_IF(Instr1_IF), .Instr_PC_IF(Instr_PC_IF), .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF),
        .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .Instr1_OUT(Instr1_OUT),
        .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4(Instr_PC_Plus4),
        .COUNT(COUNT), .FLUSH_DROPS(FLUSH_DROPS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        entry_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        check("count", 64'(COUNT), 64'(mq.size()));
        check("out_valid", 64'(OUT_VALID), 64'(mq.size() != 0));
        check("in_ready", 64'(IN_READY), 64'(mq.size() < DEPTH));
        check("head_instr", 64'(Instr1_OUT), 64'(h.instr));
        check("head_pc", 64'(Instr_PC_OUT), 64'(h.pc));
        check("head_pc4", 64'(Instr_PC_Plus4), 64'(h.pc4));
        check("flush_drops", 64'(FLUSH_DROPS), 64'(m_drops));
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare after it.
    task automatic step(input logic rst, input logic fl, input logic st, input logic iv,
                        input logic [31:0] ins, input logic [31:0] p, input logic [31:0] p4);
        entry_t tmp;
        int     sz;
        @(negedge CLK);
        RESET = rst; FLUSH = fl; STALL = st; IN_VALID = iv;
        Instr1_IF = ins; Instr_PC_IF = p; Instr_PC_Plus4_IF = p4;
        @(posedge CLK);
        sz = mq.size();
        if (rst) begin
            mq.delete();
            m_drops = 0;
        end else if (fl) begin
            m_drops = (m_drops + sz > 65535) ? 65535 : m_drops + sz;
            mq.delete();
        end else begin
            if (sz > 0 && !st) tmp = mq.pop_front();
            if (iv && sz < DEPTH) mq.push_back('{instr: ins, pc: p, pc4: p4});
        end
        #1;
        check_all();
    endtask

    task automatic push_pc(input logic st, input logic [31:0] p);
        step(1'b0, 1'b0, st, 1'b1, $urandom, p, p + 32'd4);
    endtask

    task automatic idle(input logic st);
        step(1'b0, 1'b0, st, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        check("rst_count", 64'(COUNT), 64'd0);
        check("rst_ready", 64'(IN_READY), 64'd1);

        // Single entry: visible one cycle after the push, then gone.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h8C22_0004, 32'h0040_0000, 32'h0040_0004);
        check("lat_valid", 64'(OUT_VALID), 64'd1);
        check("lat_instr", 64'(Instr1_OUT), 64'h8C22_0004);
        check("lat_pc", 64'(Instr_PC_OUT), 64'h0040_0000);
        idle(1'b0);
        check("bubble_pc4", 64'(Instr_PC_Plus4), 64'd0);

        // Fill while stalled; the fifth push is refused.
        for (int i = 0; i < 5; i++) push_pc(1'b1, 32'h100 + 32'(4 * i));
        check("full_count", 64'(COUNT), 64'd4);
        check("full_ready", 64'(IN_READY), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(Instr_PC_OUT), 64'(32'h100 + 32'(4 * i)));
            idle(1'b0);
        end
        check("drained", 64'(COUNT), 64'd0);

        // Steady state with simultaneous push and pop; pointers wrap.
        push_pc(1'b1, 32'h200);
        push_pc(1'b1, 32'h204);
        for (int i = 0; i < 10; i++) begin
            check("steady_pc", 64'(Instr_PC_OUT), 64'(32'h200 + 32'(4 * i)));
            push_pc(1'b0, 32'h208 + 32'(4 * i));
            check("steady_count", 64'(COUNT), 64'd2);
        end

        // Flush with three entries, input and stall both active.
        push_pc(1'b1, 32'h300);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h400, 32'h404);
        check("flush_count", 64'(COUNT), 64'd0);
        check("flush_valid", 64'(OUT_VALID), 64'd0);
        check("flush_drops3", 64'(FLUSH_DROPS), 64'd3);

        // Reset wins over flush: drops cleared, none added.
        push_pc(1'b1, 32'h500);
        push_pc(1'b1, 32'h504);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3);
        check("rstfl_count", 64'(COUNT), 64'd0);
        check("rstfl_drops", 64'(FLUSH_DROPS), 64'd0);

        // Saturation of the drop counter from a preset value.
        for (int i = 0; i < 4; i++) push_pc(1'b1, 32'h600 + 32'(4 * i));
        @(negedge CLK);
        force dut.flush_drops_q = 16'hFFFE;
        #1;
        release dut.flush_drops_q;
        m_drops = 32'hFFFE;
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        check("sat_drops", 64'(FLUSH_DROPS), 64'hFFFF);
        push_pc(1'b1, 32'h700);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        check("sat_hold", 64'(FLUSH_DROPS), 64'hFFFF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p;
            p = $urandom;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, p, p + 32'd4);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_pipe_buffer.md
INSTR_PIPE_BUFFER -- requirements
Module: instr_pipe_buffer

Interface
REQ-001 Parameter DATA_W, default 32, width of the instruction word field.
REQ-002 Parameter DEPTH, default 4, number of buffered entries; legal range 2..16, need not be a power of two.
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of COUNT.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset, sampled on rising edge of CLK.
REQ-006 FLUSH  in  1  discard all buffered entries (branch mispredict/redirect).
REQ-007 STALL  in  1  downstream (ID) not accepting; head entry held.
REQ-008 IN_VALID  in  1  IF presents a fetched entry this cycle.
REQ-009 Instr1_IF  in  DATA_W  fetched instruction.
REQ-010 Instr_PC_IF  in  32  address of fetched instruction.
REQ-011 Instr_PC_Plus4_IF  in  32  address of following instruction.
REQ-012 IN_READY  out  1  buffer can accept an entry this cycle.
REQ-013 OUT_VALID  out  1  head entry valid for ID.
REQ-014 Instr1_OUT  out  DATA_W  head instruction.
REQ-015 Instr_PC_OUT  out  32  head PC.
REQ-016 Instr_PC_Plus4  out  32  head next-PC.
REQ-017 COUNT  out  CW  number of occupied entries, 0..DEPTH.
REQ-018 FLUSH_DROPS  out  16  saturating count of valid entries discarded by FLUSH.

Function
REQ-019 Storage SHALL be a circular queue of DEPTH entries {instr, pc, pc_plus4} with write and read pointers wrapping DEPTH-1 -> 0.
REQ-020 Push SHALL occur when IN_VALID && IN_READY && !FLUSH; entry written at write pointer, pointer advances.
REQ-021 Pop SHALL occur when OUT_VALID && !STALL && !FLUSH; read pointer advances.
REQ-022 IN_READY SHALL equal (COUNT < DEPTH), depending on registered state only, with no combinational path from STALL.
REQ-023 OUT_VALID SHALL equal (COUNT != 0).
REQ-024 Head outputs SHALL show the entry at the read pointer when OUT_VALID=1 and SHALL be all-zero (bubble/NOP) when OUT_VALID=0.
REQ-025 Latency: an entry pushed at edge N SHALL be visible on the head outputs in the cycle after edge N when the buffer was empty before edge N.
REQ-026 Simultaneous push and pop SHALL leave COUNT unchanged and preserve FIFO order.
REQ-027 Full (COUNT=DEPTH): IN_READY=0, IN_VALID ignored; a pop in that cycle SHALL NOT permit a same-cycle push.
REQ-028 Empty: STALL has no effect; pop SHALL NOT occur.
REQ-029 FLUSH SHALL, at the edge, set COUNT=0, reset both pointers to 0, and ignore that cycle's push and pop.
REQ-030 FLUSH SHALL add the pre-flush COUNT to FLUSH_DROPS, saturating at 16'hFFFF.
REQ-031 FLUSH SHALL take priority over STALL and IN_VALID; RESET SHALL take priority over FLUSH.
REQ-032 Storage contents of unoccupied entries SHALL NOT be observable on any output.

Reset
REQ-033 With RESET=1 at an edge: COUNT=0, pointers=0, FLUSH_DROPS=0, OUT_VALID=0, IN_READY=1, head outputs all-zero.
REQ-034 RESET asserted mid-operation SHALL discard all entries without incrementing FLUSH_DROPS, even with FLUSH=1 in the same cycle.
REQ-035 Storage arrays need no reset.

Verification
REQ-036 Reset then push {instr=0x8C220004, pc=0x00400000, pc4=0x00400004}, STALL=0 -> next cycle OUT_VALID=1 with those values; following cycle OUT_VALID=0, outputs zero.
REQ-037 STALL=1, push 5 entries pc=0x100,0x104,... with DEPTH=4 -> COUNT reaches 4, IN_READY=0, 5th entry not accepted; release STALL -> pops 0x100..0x10C in order.
REQ-038 COUNT=2, push and pop same cycle, 10 cycles -> COUNT stays 2, pointers wrap, order preserved.
REQ-039 COUNT=3 and FLUSH=1 with IN_VALID=1 and STALL=1 -> next cycle COUNT=0, OUT_VALID=0, FLUSH_DROPS=3, flushing-cycle input dropped.
REQ-040 FLUSH_DROPS preset near 16'hFFFE, flush with COUNT=4 -> FLUSH_DROPS=16'hFFFF.
REQ-041 RESET=1 and FLUSH=1 with COUNT=2 -> COUNT=0, FLUSH_DROPS=0.
